// File: rtl/bash_f_round_ctrl.sv
// Round sequencer for the bash-f permutation: owns the round-constant register,
// walks ROUNDS rounds with stall support, and signals completion with done_o.

module bash_f_const (
    input  logic [63:0] data_i,
    output logic [63:0] data_o
);
    localparam logic [63:0] C_POLY = 64'hDC2BE1997FE0D8AE;

    logic [63:0] le_word;
    logic [63:0] le_next;

    // Byte 0 of the word sits in [63:56] but is the least significant byte of the integer.
    always_comb begin
        le_word = '0;
        data_o  = '0;
        for (int b = 0; b < 8; b++) begin
            le_word[8*b +: 8] = data_i[63-8*b -: 8];
        end
        le_next = (le_word >> 1) ^ (le_word[0] ? C_POLY : 64'h0);
        for (int b = 0; b < 8; b++) begin
            data_o[63-8*b -: 8] = le_next[8*b +: 8];
        end
    end
endmodule

module bash_f_round_ctrl #(
    parameter int          ROUNDS = 24,
    parameter logic [63:0] C_INIT = 64'hB194BAC80A08F53B,
    localparam int         IW     = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          stall_i,
    output logic          ready_o,
    output logic          round_en_o,
    output logic [IW-1:0] round_idx_o,
    output logic [63:0]   round_const_o,
    output logic          last_round_o,
    output logic          done_o,
    output logic [1:0]    state_o
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IW-1:0] IDX_LAST = IW'(ROUNDS - 1);

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [63:0]   const_q, const_d;
    logic [63:0]   const_next;

    bash_f_const u_const (
        .data_i (const_q),
        .data_o (const_next)
    );

    // Valid/ready: start_i is accepted only in a cycle with ready_o=1; round_en_o
    // marks a round consumed by the datapath, which happens only while stall_i=0.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        const_d = const_q;
        case (state_q)
            S_IDLE: begin
                idx_d   = '0;
                const_d = C_INIT;
                if (start_i) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!stall_i) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = S_DONE;
                        idx_d   = '0;
                        const_d = C_INIT;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        const_d = const_next;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
                const_d = C_INIT;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            const_q <= C_INIT;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            const_q <= const_d;
        end
    end

    assign ready_o       = (state_q == S_IDLE);
    assign round_en_o    = (state_q == S_RUN) && !stall_i;
    assign round_idx_o   = idx_q;
    assign round_const_o = const_q;
    assign last_round_o  = (state_q == S_RUN) && (idx_q == IDX_LAST);
    assign done_o        = (state_q == S_DONE);
    assign state_o       = state_q;
endmodule
